// File: rtl/store_trace_monitor.sv
// store_trace_monitor: taps the core's data-memory store port, queues every
// store {DataAdr, WriteData} into a DEPTH-entry trace FIFO drained over a
// valid/ready handshake, and runs a RUN/PASS/FAIL verdict FSM for
// self-checking programs.
// Optional build macro STORE_TRACE_TIMEOUT_EN adds a RUN-state watchdog that
// forces FAIL after TIMEOUT cycles without a verdict.
module store_trace_monitor #(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] PASS_ADDR    = 32'd108,
    parameter logic [31:0] PASS_DATA    = 32'hABCDE7E5,
    parameter logic [31:0] SCRATCH_ADDR = 32'd96,
    parameter logic [31:0] TIMEOUT      = 32'd300
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         MemWrite,
    input  logic [31:0]                  DataAdr,
    input  logic [31:0]                  WriteData,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_addr,
    output logic [31:0]                  out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         done,
    output logic                         pass
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {RUN, PASS, FAIL} state_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            full, pop, push_ok;
    entry_t          head_nxt;
    state_t          state;

    assign full    = (count == CW'(DEPTH));
    assign pop     = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = MemWrite && (!full || pop);
    assign rd_nxt  = pop ? rd_ptr + 1'b1 : rd_ptr;

    // Next occupancy: only push-only or pop-only edges move the count.
    always_comb begin
        cnt_nxt = count;
        case ({push_ok, pop})
            2'b10:   cnt_nxt = count + 1'b1;
            2'b01:   cnt_nxt = count - 1'b1;
            default: cnt_nxt = count;
        endcase
    end

    // Next head: bypass the incoming store when it lands in the head slot.
    always_comb begin
        head_nxt = mem[rd_nxt];
        if (push_ok && (wr_ptr == rd_nxt))
            head_nxt = '{addr: DataAdr, data: WriteData};
    end

    // Trace storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= '{addr: DataAdr, data: WriteData};
    end

    // Pointers, occupancy, registered head and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr    <= rd_nxt;
            count     <= cnt_nxt;
            out_valid <= (cnt_nxt != '0);
            if (cnt_nxt != '0) begin
                out_addr <= head_nxt.addr;
                out_data <= head_nxt.data;
            end
            if (MemWrite && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Verdict for one store while in RUN. Written as an if-chain so an X
    // address or data falls through to FAIL in simulation.
    function automatic state_t decide(input logic [31:0] a, input logic [31:0] d);
        state_t s;
        s = FAIL;
        if (a == PASS_ADDR) begin
            if (d == PASS_DATA)
                s = PASS;
            else
                s = FAIL;
        end else if (a == SCRATCH_ADDR) begin
            s = RUN;
        end else begin
            s = FAIL;
        end
        return s;
    endfunction

`ifdef STORE_TRACE_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    // Watchdog counts RUN cycles and freezes once a verdict exists.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state == RUN)
            tmo_cnt <= tmo_cnt + 32'd1;
    end
`endif

    // Verdict FSM with registered done/pass; PASS and FAIL are terminal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else if (state == RUN) begin
            if (MemWrite && (decide(DataAdr, WriteData) != RUN)) begin
                state <= decide(DataAdr, WriteData);
                done  <= 1'b1;
                pass  <= (decide(DataAdr, WriteData) == PASS);
            end
`ifdef STORE_TRACE_TIMEOUT_EN
            else if (tmo_cnt == TIMEOUT - 32'd1) begin
                state <= FAIL;
                done  <= 1'b1;
                pass  <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_store_trace_monitor.sv
// Bench for store_trace_monitor: a verdict vector table plus hand-written
// sequences for fill/overflow, full push+pop, async reset and timeout. A
// reference queue of expected trace entries is checked against each pop.
module tb_store_trace_monitor;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_addr, out_data;
    logic [3:0]  count;
    logic        overflow, done, pass;

    store_trace_monitor #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .count(count),
        .overflow(overflow), .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        do_rst;
        logic        mw;
        logic [31:0] a;
        logic [31:0] d;
        logic        e_done;
        logic        e_pass;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    int   mcount = 0;
    logic mover = 1'b0;
    int   npops = 0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: mirrors occupancy/overflow and scores each popped head.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mcount = 0;
            mover  = 1'b0;
        end else begin
            logic do_pop;
            chk("count", 64'(count), 64'(mcount));
            chk("overflow", 64'(overflow), 64'(mover));
            chk("out_valid", 64'(out_valid), 64'(mcount != 0));
            do_pop = (mcount != 0) && out_ready;
            if (do_pop) begin
                chk("head_addr", 64'(out_addr), 64'(q[0].a));
                chk("head_data", 64'(out_data), 64'(q[0].d));
                last_data = q[0].d;
                void'(q.pop_front());
                mcount--;
                npops++;
            end
            if (MemWrite) begin
                if (mcount == DEPTH) mover = 1'b1;
                else begin
                    q.push_back('{a: DataAdr, d: WriteData});
                    mcount++;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        MemWrite = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; DataAdr = a; WriteData = d;
        @(posedge clk); #1;
        MemWrite = 1'b0;
    endtask

    vec_t vt[8];

    initial begin
        int np0;
        vt[0] = '{1'b1, 1'b1, 32'd96,  32'd7,        1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 32'd96,  32'd25,       1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 32'd108, 32'hABCDE7E5, 1'b1, 1'b1};
        vt[3] = '{1'b0, 1'b0, 32'd0,   32'd0,        1'b1, 1'b1};
        vt[4] = '{1'b1, 1'b1, 32'd108, 32'h1,        1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b1, 32'd108, 32'hABCDE7E5, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b0, 32'd0,   32'd0,        1'b1, 1'b0};
        vt[7] = '{1'b0, 1'b1, 32'd96,  32'd3,        1'b1, 1'b0};

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_addr", 64'(out_addr), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Verdict table: pass program, then fail-then-late-pass
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (vt[i].do_rst) do_reset();
            MemWrite = vt[i].mw; DataAdr = vt[i].a; WriteData = vt[i].d;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done", i), 64'(done), 64'(vt[i].e_done));
            chk($sformatf("vec%0d_pass", i), 64'(pass), 64'(vt[i].e_pass));
        end
        MemWrite = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("table_drained", 64'(q.size()), 64'd0);

        // Overflow: DEPTH+1 stores with drain stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) store(32'd96, 32'd100 + 32'(i));
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_hold_addr", 64'(out_addr), 64'd96);
        chk("ovf_hold_data", 64'(out_data), 64'd100);
        chk("ovf_done", 64'(done), 64'd0);
        np0 = npops;
        out_ready = 1'b1;
        repeat (12) @(posedge clk); #1;
        chk("ovf_drain_n", 64'(npops - np0), 64'd8);
        chk("ovf_last", 64'(last_data), 64'd107);

        // Full FIFO with push and pop on the same edge
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) store(32'd96, 32'd200 + 32'(i));
        out_ready = 1'b1;
        store(32'd96, 32'd999);
        chk("fpp_count", 64'(count), 64'd8);
        chk("fpp_ovf", 64'(overflow), 64'd0);
        np0 = npops;
        repeat (12) @(posedge clk); #1;
        chk("fpp_drain_n", 64'(npops - np0), 64'd8);
        chk("fpp_last", 64'(last_data), 64'd999);

        // Fail on stray address, then async reset mid-drain
        do_reset();
        out_ready = 1'b0;
        store(32'd100, 32'd1);
        chk("f100_done", 64'(done), 64'd1);
        chk("f100_pass", 64'(pass), 64'd0);
        for (int i = 0; i < DEPTH; i++) store(32'd96, 32'(i));
        out_ready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_done", 64'(done), 64'd0);
        chk("ar_ovf", 64'(overflow), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle RUN: watchdog fires only in the timeout build
        repeat (299) @(posedge clk); #1;
        chk("tmo_early", 64'(done), 64'd0);
        @(posedge clk); #1;
`ifdef STORE_TRACE_TIMEOUT_EN
        chk("tmo_done", 64'(done), 64'd1);
        chk("tmo_pass", 64'(pass), 64'd0);
`else
        chk("tmo_none", 64'(done), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
